// File: rtl/display_timing_gen.sv
// -----------------------------------------------------------------------------
// display_timing_gen
//
// Raster timing generator. Walks a signed (x, y) position across the full
// frame, blanking included. Coordinates are negative during blanking and reach
// (0,0) on the first active pixel, so downstream renderers can use them as
// pixel addresses directly.
//
// The horizontal counter is a four-phase walk (FRONT, SYNC, BACK, ACTIVE)
// whose phase changes at fixed x boundaries. The vertical counter runs the
// same walk but only advances when x wraps.
//
// Every output is a register loaded from the next-state position in the same
// cycle. Coordinates and strobes therefore always describe the same pixel.
//
// Optional feature macro: DISPLAY_TIMING_FRAME_CNT_EN
//   When defined, adds the o_frame port and its 16-bit frame counter.
//
// Ports
//   CLK            pixel/system clock
//   RST_N          asynchronous active-low reset
//   i_en           pixel strobe; the position advances only on edges where
//                  it is high
//   o_x, o_y       signed 16-bit coordinates
//   o_hsync        horizontal sync, active level set by H_POL
//   o_vsync        vertical sync, active level set by V_POL
//   o_de           data enable (o_x >= 0 and o_y >= 0)
//   o_line_start   one-CLK pulse on entering x = H_STA
//   o_frame_start  one-CLK pulse on entering (H_STA, V_STA)
//   o_h_res        constant H_RES
//   o_v_res        constant V_RES
//   o_frame        frame count (only with DISPLAY_TIMING_FRAME_CNT_EN)
//
// Legal parameters: every porch and sync width is >= 1,
// H_RES and V_RES are <= 4095, and resolution plus blanking is <= 32767.
// -----------------------------------------------------------------------------
module display_timing_gen #(
  parameter int H_RES  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_RES  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int H_POL  = 0,
  parameter int V_POL  = 0
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               i_en,
  output logic signed [15:0] o_x,
  output logic signed [15:0] o_y,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_de,
  output logic               o_line_start,
  output logic               o_frame_start,
  output logic        [11:0] o_h_res,
  output logic        [11:0] o_v_res
`ifdef DISPLAY_TIMING_FRAME_CNT_EN
  ,
  output logic        [15:0] o_frame
`endif
);

  // ---------------------------------------------------------------------------
  // Derived timing constants. The blanking interval precedes the active
  // region, so every phase boundary is a fixed signed coordinate.
  // ---------------------------------------------------------------------------
  localparam int H_BLANK = H_FP + H_SYNC + H_BP;
  localparam int V_BLANK = V_FP + V_SYNC + V_BP;

  localparam logic signed [15:0] H_STA      = 16'(-H_BLANK);
  localparam logic signed [15:0] H_SYNC_STA = 16'(H_FP - H_BLANK);
  localparam logic signed [15:0] H_BP_STA   = 16'(-H_BP);
  localparam logic signed [15:0] H_END      = 16'(H_RES - 1);

  localparam logic signed [15:0] V_STA      = 16'(-V_BLANK);
  localparam logic signed [15:0] V_SYNC_STA = 16'(V_FP - V_BLANK);
  localparam logic signed [15:0] V_BP_STA   = 16'(-V_BP);
  localparam logic signed [15:0] V_END      = 16'(V_RES - 1);

  // Active levels of the sync outputs.
  localparam logic H_ACT = (H_POL != 0);
  localparam logic V_ACT = (V_POL != 0);

  // Reject parameter sets that would overflow the 16-bit signed coordinate
  // space or the 12-bit resolution outputs, or that leave a phase empty.
  // An empty phase would merge two boundaries into one coordinate.
  if (H_RES < 1 || H_RES > 4095 || V_RES < 1 || V_RES > 4095 ||
      H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      H_RES + H_BLANK > 32767 || V_RES + V_BLANK > 32767) begin : g_bad_params
    $error("display_timing_gen: illegal timing parameters");
  end

  typedef enum logic [1:0] {
    PH_FRONT  = 2'd0,
    PH_SYNC   = 2'd1,
    PH_BACK   = 2'd2,
    PH_ACTIVE = 2'd3
  } phase_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic signed [15:0] x_reg, y_reg;
  phase_t             h_phase_reg, v_phase_reg;
  logic               hsync_reg, vsync_reg, de_reg;
  logic               line_start_reg, frame_start_reg;

  // Next-state values assuming the position advances this cycle. They are
  // only loaded when i_en is high.
  logic signed [15:0] x_next, y_next;
  phase_t             h_phase_next, v_phase_next;
  logic               h_wrap, v_wrap;

  always_comb begin
    h_wrap = (x_reg == H_END);
    v_wrap = h_wrap && (y_reg == V_END);

    x_next = h_wrap ? H_STA : x_reg + 16'sd1;

    y_next = y_reg;
    if (h_wrap) begin
      y_next = (y_reg == V_END) ? V_STA : y_reg + 16'sd1;
    end

    // The horizontal walk changes phase only at the entry coordinate of each
    // phase and holds the current phase at every other coordinate.
    h_phase_next = h_phase_reg;
    if (x_next == H_STA) begin
      h_phase_next = PH_FRONT;
    end else if (x_next == H_SYNC_STA) begin
      h_phase_next = PH_SYNC;
    end else if (x_next == H_BP_STA) begin
      h_phase_next = PH_BACK;
    end else if (x_next == 16'sd0) begin
      h_phase_next = PH_ACTIVE;
    end

    // The vertical walk is the same, but it is clocked by the x wrap. This
    // keeps vsync edges aligned to line boundaries.
    v_phase_next = v_phase_reg;
    if (h_wrap) begin
      if (y_next == V_STA) begin
        v_phase_next = PH_FRONT;
      end else if (y_next == V_SYNC_STA) begin
        v_phase_next = PH_SYNC;
      end else if (y_next == V_BP_STA) begin
        v_phase_next = PH_BACK;
      end else if (y_next == 16'sd0) begin
        v_phase_next = PH_ACTIVE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered position and strobes.
  //
  // Reset parks the position on the last pixel of the frame, so the first
  // enabled edge wraps to (H_STA, V_STA) and raises both start pulses.
  //
  // The pulses clear on every edge without an enable, which keeps each pulse
  // exactly one CLK wide. All other outputs hold while i_en is low.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      x_reg           <= H_END;
      y_reg           <= V_END;
      h_phase_reg     <= PH_ACTIVE;
      v_phase_reg     <= PH_ACTIVE;
      hsync_reg       <= ~H_ACT;
      vsync_reg       <= ~V_ACT;
      de_reg          <= 1'b0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      if (i_en) begin
        x_reg           <= x_next;
        y_reg           <= y_next;
        h_phase_reg     <= h_phase_next;
        v_phase_reg     <= v_phase_next;
        hsync_reg       <= (h_phase_next == PH_SYNC) ? H_ACT : ~H_ACT;
        vsync_reg       <= (v_phase_next == PH_SYNC) ? V_ACT : ~V_ACT;
        de_reg          <= (h_phase_next == PH_ACTIVE) && (v_phase_next == PH_ACTIVE);
        line_start_reg  <= h_wrap;
        frame_start_reg <= v_wrap;
      end
    end
  end

`ifdef DISPLAY_TIMING_FRAME_CNT_EN
  // The frame counter steps on the same edge that raises o_frame_start, so
  // the first frame after reset reads 1. It wraps naturally at 16 bits.
  logic [15:0] frame_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      frame_reg <= 16'd0;
    end else if (i_en && v_wrap) begin
      frame_reg <= frame_reg + 16'd1;
    end
  end

  assign o_frame = frame_reg;
`endif

  assign o_x           = x_reg;
  assign o_y           = y_reg;
  assign o_hsync       = hsync_reg;
  assign o_vsync       = vsync_reg;
  assign o_de          = de_reg;
  assign o_line_start  = line_start_reg;
  assign o_frame_start = frame_start_reg;
  assign o_h_res       = 12'(H_RES);
  assign o_v_res       = 12'(V_RES);

endmodule

// File: doc/display_timing_gen.md
# display_timing_gen

Raster timing generator for the video pipeline, placed directly upstream of the pixel renderers. It produces the signed pixel coordinates `o_x`/`o_y`, the sync and data-enable strobes, line and frame markers, and the active resolution. Renderers consume the coordinates and resolution and return RGB. Coordinates are negative during blanking and start at (0,0) on the first active pixel, so renderers need no offset arithmetic.

## Interface
Parameters:
- `H_RES`, 640: active pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_RES`, 480: active lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `H_POL`, 0: hsync active level (0 = active-low).
- `V_POL`, 0: vsync active level (0 = active-low).

Ports (one clock; reset is asynchronous and active-low):
- `CLK`  in  1  system/pixel clock.
- `RST_N`  in  1  asynchronous active-low reset.
- `i_en`  in  1  pixel strobe; counters advance only on edges where it is high.
- `o_x`  out  16 signed  horizontal coordinate.
- `o_y`  out  16 signed  vertical coordinate.
- `o_hsync`  out  1  horizontal sync, level set by `H_POL`.
- `o_vsync`  out  1  vertical sync, level set by `V_POL`.
- `o_de`  out  1  high when `o_x`≥0 and `o_y`≥0.
- `o_line_start`  out  1  one-CLK pulse on entering `o_x`=H_STA.
- `o_frame_start`  out  1  one-CLK pulse on entering (H_STA, V_STA).
- `o_h_res`  out  12  constant `H_RES`.
- `o_v_res`  out  12  constant `V_RES`.
- `o_frame`  out  16  frame count. Present only with `DISPLAY_TIMING_FRAME_CNT_EN`.

## Operation
- Derived values: H_STA = −(H_FP+H_SYNC+H_BP), V_STA = −(V_FP+V_SYNC+V_BP). Defaults give −160 and −45.
- `o_x` range: H_STA to H_RES−1. `o_y` range: V_STA to V_RES−1.
- Advance on each `i_en` edge:
  - x increments.
  - At H_RES−1, x wraps to H_STA and y increments.
  - At (H_RES−1, V_RES−1), the position wraps to (H_STA, V_STA).
- hsync is active for x in [H_STA+H_FP, H_STA+H_FP+H_SYNC−1]. Defaults: −144 to −49.
- vsync is active for y in [V_STA+V_FP, V_STA+V_FP+V_SYNC−1]. Defaults: −35 to −34.
- vsync changes together with x wrap, at line boundaries only.
- Arithmetic:
  - All comparisons are signed 16-bit.
  - Parameters are legal only if H_RES+blank ≤ 32767 and H_RES, V_RES ≤ 4095.
  - Every porch and sync parameter must be ≥1.
- State: the horizontal counter is a 4-phase walk (FRONT, SYNC, BACK, ACTIVE), decoded from x. The vertical counter is the same walk, advanced only on x wrap.

## Timing
- All outputs are registered, with zero skew between coordinates and strobes: every strobe is a function of the `o_x`/`o_y` value presented in the same cycle. Strobes are computed from next-state counters.
- Reset values while `RST_N`=0:
  - Internal position is (H_RES−1, V_RES−1).
  - `o_x`=H_RES−1, `o_y`=V_RES−1.
  - `o_de`=0, syncs inactive, pulses 0, `o_frame`=0.
- Release: on the first `i_en` edge after `RST_N` rises, the outputs show (H_STA, V_STA) and `o_frame_start`=`o_line_start`=1.
- `i_en` low: all outputs hold, and both pulses drop to 0 after one CLK, so each pulse is always exactly one CLK wide.
- Reset asserted mid-frame: outputs go to reset values immediately (asynchronously). Counting restarts cleanly, with no partial line or frame state retained.
- Default timing: line = 800 strobes, frame = 525 lines = 420 000 strobes.

## Configuration
- `DISPLAY_TIMING_FRAME_CNT_EN` defined:
  - `o_frame` is present.
  - It increments in the same cycle `o_frame_start` asserts, starting 0→1 at the first frame after reset.
  - It wraps 0xFFFF→0x0000.
- Not defined: the port and its counter are absent. All other behaviour is identical.

## Test plan
- Reset then release with `i_en`=1 → first cycle shows x=−160, y=−45, `o_frame_start`=1 and `o_line_start`=1; the next cycle shows x=−159 with both pulses 0.
- Run one line → hsync low for exactly 96 cycles starting at x=−144; `o_de` high for x=0..639 at y≥0 only; `o_line_start` every 800 cycles.
- Run a full frame → vsync low for lines −35 and −34 (1600 cycles); `o_frame_start` period 420 000 cycles; wrap from (639,479) to (−160,−45).
- `i_en` toggled 1-of-4 → coordinates step every 4 CLK; each pulse is 1 CLK wide; line period is 3200 CLK.
- Reset asserted at (100,200) → outputs immediately show (639,479) with de=0; release resumes at (−160,−45).
- With `DISPLAY_TIMING_FRAME_CNT_EN`, small parameters (H 4/1/1/1, V 2/1/1/1) → `o_frame` reads 3 after 3 frame-start pulses; a forced value of 0xFFFF wraps to 0.
